ram_arbiter: RTL

- Shares the single-port program/data RAM between two requesters: the SUBLEQ control path (cpu port) and a program loader/debug port (ldr port).
- Each requester runs a req/ack handshake. The arbiter picks one owner, drives the RAM for a fixed number of access cycles, returns registered read data and pulses ack.
- Sits between the control unit/address mux and the RAM. Lets programs be loaded or inspected without stopping the clock.

---
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/ram_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: cpu and loader request ports plus the shared RAM bus of ram_arbiter
interface ram_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_adr;
   logic [DW-1:0] cpu_wdat;
   logic [DW-1:0] cpu_rdat;
   logic          cpu_ack;
   logic          ldr_req;
   logic          ldr_we;
   logic [AW-1:0] ldr_adr;
   logic [DW-1:0] ldr_wdat;
   logic [DW-1:0] ldr_rdat;
   logic          ldr_ack;
   logic          ram_ena;
   logic          ram_ctl;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_wdo;
   logic [DW-1:0] ram_rdi;
   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wdat,
      input  ldr_req, ldr_we, ldr_adr, ldr_wdat,
      input  ram_rdi,
      output cpu_rdat, cpu_ack, ldr_rdat, ldr_ack,
      output ram_ena, ram_ctl, ram_adr, ram_wdo
   );
   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wdat,
      output ldr_req, ldr_we, ldr_adr, ldr_wdat,
      output ram_rdi,
      input  cpu_rdat, cpu_ack, ldr_rdat, ldr_ack,
      input  ram_ena, ram_ctl, ram_adr, ram_wdo
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the cpu and loader ports; round-robin by default, LDR_PRIO_EN gives the loader fixed priority
module ram_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int ACC_CYC = 2
) (
   input  logic           clk,
   input  logic           res,
   ram_arbiter_if.slave   bus,
   output logic           busy,
   output logic           owner
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          last;
   logic          gnt;
   logic          g_we;
   logic [AW-1:0] g_adr;
   logic [DW-1:0] g_wdat;
   assign busy = state != IDLE;
   // choose the winner among pending requests and select its qualifiers
   always_comb begin
`ifdef LDR_PRIO_EN
      gnt    = bus.ldr_req;
`else
      gnt    = (bus.cpu_req && bus.ldr_req) ? ~last : bus.ldr_req;
`endif
      g_we   = gnt ? bus.ldr_we   : bus.cpu_we;
      g_adr  = gnt ? bus.ldr_adr  : bus.cpu_adr;
      g_wdat = gnt ? bus.ldr_wdat : bus.cpu_wdat;
   end
   // grant, hold the RAM for ACC_CYC cycles, then return data and pulse ack
   always_ff @(posedge clk) begin
      if (res) begin
         state        <= IDLE;
         cnt          <= '0;
         last         <= 1'b1;
         owner        <= 1'b1;
         bus.ram_ena  <= 1'b0;
         bus.ram_ctl  <= 1'b0;
         bus.ram_adr  <= '0;
         bus.ram_wdo  <= '0;
         bus.cpu_ack  <= 1'b0;
         bus.ldr_ack  <= 1'b0;
         bus.cpu_rdat <= '0;
         bus.ldr_rdat <= '0;
      end else begin
         bus.cpu_ack <= 1'b0;
         bus.ldr_ack <= 1'b0;
         case (state)
            IDLE: if (bus.cpu_req || bus.ldr_req) begin
               owner       <= gnt;
               bus.ram_ena <= 1'b1;
               bus.ram_ctl <= g_we;
               bus.ram_adr <= g_adr;
               bus.ram_wdo <= g_we ? g_wdat : '0;
               cnt         <= 4'(ACC_CYC - 1);
               state       <= ACCESS;
            end
            ACCESS: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else begin
               bus.ram_ena <= 1'b0;
               bus.ram_ctl <= 1'b0;
               state       <= DONE;
               if (owner) bus.ldr_ack <= 1'b1;
               else bus.cpu_ack <= 1'b1;
               if (!bus.ram_ctl && owner) bus.ldr_rdat <= bus.ram_rdi;
               if (!bus.ram_ctl && !owner) bus.cpu_rdat <= bus.ram_rdi;
            end
            DONE: begin
               last  <= owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
